// File: rtl/oled_stream_driver.sv
// rtl/oled_stream_driver.sv - serial pixel streamer for a 96x64 RGB565 OLED panel
// Sequences panel reset, init commands, then WINDOW + PIXELS frames forever.
module oled_stream_driver #(
  parameter int CLK_DIV    = 2,
  parameter int RES_CYCLES = 100,
  parameter int POWER_WAIT = 200,
  parameter int NUM_PIXELS = 6144
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [12:0] pixel_index,
  input  logic [15:0] oled_data,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        res_n,
  output logic        frame_begin
);

  typedef enum logic [2:0] {RES_LOW, PWR_WAIT, INIT, WINDOW, PIXELS} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        busy_q, busy_d;
  logic [7:0]  div_q, div_d;
  logic        half_q, half_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [12:0] pix_q, pix_d;
  logic        fb_q, fb_d;
  logic        start;
  logic        start_pix;
  logic [15:0] start_word;

  function automatic logic [7:0] cmd_byte(input state_e st, input logic [2:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (st == INIT) begin
      case (i)
        3'd0:    b = 8'hAE;
        3'd1:    b = 8'hA0;
        3'd2:    b = 8'h72;
        default: b = 8'hAF;
      endcase
    end else begin
      case (i)
        3'd0:    b = 8'h15;
        3'd1:    b = 8'h00;
        3'd2:    b = 8'h5F;
        3'd3:    b = 8'h75;
        3'd4:    b = 8'h00;
        default: b = 8'h3F;
      endcase
    end
    return b;
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= RES_LOW;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      fb_q    <= fb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    busy_d     = busy_q;
    div_d      = div_q;
    half_d     = half_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    fb_d       = 1'b0;
    start      = 1'b0;
    start_pix  = 1'b0;
    start_word = '0;
    case (state_q)
      RES_LOW: begin
        if (wait_q == 16'(RES_CYCLES - 1)) begin
          state_d = PWR_WAIT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      PWR_WAIT: begin
        // First command unit starts with no cs gap in front of it
        if (wait_q == 16'(POWER_WAIT - 1)) begin
          state_d    = INIT;
          idx_d      = '0;
          start      = 1'b1;
          start_word = {cmd_byte(INIT, 3'd0), 8'h00};
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        if (busy_q) begin
          if (div_q != 8'(CLK_DIV - 1)) begin
            div_d = div_q + 8'd1;
          end else begin
            div_d = '0;
            if (!half_q) begin
              half_d = 1'b1;
            end else if (bit_q != 4'd0) begin
              half_d  = 1'b0;
              bit_d   = bit_q - 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
            end else begin
              // Unit done: indices advance so pixel_index moves on the first gap cycle
              busy_d = 1'b0;
              half_d = 1'b0;
              wait_d = '0;
              case (state_q)
                INIT: begin
                  if (idx_q == 3'd3) begin
                    state_d = WINDOW;
                    idx_d   = '0;
                  end else begin
                    idx_d = idx_q + 3'd1;
                  end
                end
                WINDOW: begin
                  if (idx_q == 3'd5) begin
                    state_d = PIXELS;
                    idx_d   = '0;
                    fb_d    = 1'b1;
                  end else begin
                    idx_d = idx_q + 3'd1;
                  end
                end
                default: begin
                  if (pix_q == 13'(NUM_PIXELS - 1)) begin
                    state_d = WINDOW;
                    pix_d   = '0;
                  end else begin
                    pix_d = pix_q + 13'd1;
                  end
                end
              endcase
            end
          end
        end else if (wait_q == 16'(2 * CLK_DIV - 1)) begin
          start      = 1'b1;
          start_pix  = (state_q == PIXELS);
          start_word = start_pix ? oled_data : {cmd_byte(state_q, idx_q), 8'h00};
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
    endcase
    if (start) begin
      busy_d  = 1'b1;
      div_d   = '0;
      half_d  = 1'b0;
      bit_d   = start_pix ? 4'd15 : 4'd7;
      shift_d = start_word;
      wait_d  = '0;
    end
  end

  assign cs          = ~busy_q;
  assign sclk        = busy_q ? half_q : 1'b1;
  assign sdin        = shift_q[15];
  assign d_cn        = (state_q == PIXELS);
  assign res_n       = (state_q != RES_LOW);
  assign pixel_index = pix_q;
  assign frame_begin = fb_q;

endmodule
